// File: rtl/bridge_1xn.sv
// bridge_1xn
//    Steers CPU data-side SRAM-like requests to one of N_SLV downstream slaves
//    according to cpu_data_sel. It remembers which slave owns the in-flight
//    transactions, so responses are taken from that slave even after the CPU
//    has moved its select on. A request to a different slave waits until
//    every outstanding transaction has been answered, which keeps responses
//    in order without a reorder buffer.
//
// Ports
//    clk, rst            clock, synchronous active-high reset
//    cpu_data_*          CPU request fields in, rdata/addr_ok/data_ok out
//    cpu_data_sel        target slave index for the current request
//    slv_data_*          per-slave buses, slice i of each packed vector
//                        belongs to slave i
//    stray_err           sticky: a slave returned data_ok nobody was waiting for

module bridge_1xn #(
   parameter int N_SLV   = 2,
   parameter int MAX_OUT = 4,
   parameter int SEL_W   = $clog2(N_SLV),
   parameter int CNT_W   = $clog2(MAX_OUT + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [SEL_W-1:0]      cpu_data_sel,
   input  logic                  cpu_data_req,
   input  logic                  cpu_data_wr,
   input  logic [1:0]            cpu_data_size,
   input  logic [31:0]           cpu_data_addr,
   input  logic [31:0]           cpu_data_wdata,
   output logic [31:0]           cpu_data_rdata,
   output logic                  cpu_data_addr_ok,
   output logic                  cpu_data_data_ok,
   output logic [N_SLV-1:0]      slv_data_req,
   output logic [N_SLV-1:0]      slv_data_wr,
   output logic [2*N_SLV-1:0]    slv_data_size,
   output logic [32*N_SLV-1:0]   slv_data_addr,
   output logic [32*N_SLV-1:0]   slv_data_wdata,
   input  logic [32*N_SLV-1:0]   slv_data_rdata,
   input  logic [N_SLV-1:0]      slv_data_addr_ok,
   input  logic [N_SLV-1:0]      slv_data_data_ok,
   output logic                  stray_err
);

   logic [CNT_W-1:0] out_cnt;
   logic [SEL_W-1:0] cur_tgt;
   logic             cnt_zero;
   logic             sel_ok;
   logic             allow;
   logic             push;
   logic             pop;
   logic             stray_hit;

   assign cnt_zero = (out_cnt == '0);

   // When N_SLV is not a power of two the select can name a slave that does
   // not exist; such a request is simply never accepted.
   assign sel_ok = (int'(cpu_data_sel) < N_SLV);

   // Gate works on the registered count only, so a response in the same
   // cycle never re-opens a full bridge until the next cycle.
   assign allow = !rst && cpu_data_req && sel_ok
                  && (out_cnt < CNT_W'(MAX_OUT))
                  && (cnt_zero || (cpu_data_sel == cur_tgt));

   always_comb begin
      slv_data_req     = '0;
      slv_data_wr      = '0;
      slv_data_size    = '0;
      slv_data_addr    = '0;
      slv_data_wdata   = '0;
      cpu_data_addr_ok = 1'b0;
      for (int i = 0; i < N_SLV; i++) begin
         if (allow && (int'(cpu_data_sel) == i)) begin
            slv_data_req[i]          = 1'b1;
            slv_data_wr[i]           = cpu_data_wr;
            slv_data_size[2*i +: 2]  = cpu_data_size;
            slv_data_addr[32*i +: 32]  = cpu_data_addr;
            slv_data_wdata[32*i +: 32] = cpu_data_wdata;
            cpu_data_addr_ok         = slv_data_addr_ok[i];
         end
      end
   end

   // Responses are taken only from the owner of the outstanding transactions;
   // any other data_ok (or any data_ok while idle) is a protocol violation.
   always_comb begin
      cpu_data_data_ok = 1'b0;
      cpu_data_rdata   = '0;
      stray_hit        = 1'b0;
      for (int i = 0; i < N_SLV; i++) begin
         if (!rst && !cnt_zero && (int'(cur_tgt) == i)) begin
            cpu_data_data_ok = slv_data_data_ok[i];
            cpu_data_rdata   = slv_data_rdata[32*i +: 32];
         end
         if (slv_data_data_ok[i] && (cnt_zero || (int'(cur_tgt) != i))) begin
            stray_hit = 1'b1;
         end
      end
   end

   assign push = cpu_data_addr_ok;
   assign pop  = cpu_data_data_ok;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_cnt   <= '0;
         cur_tgt   <= '0;
         stray_err <= 1'b0;
      end else begin
         if (push && !pop) begin
            out_cnt <= out_cnt + CNT_W'(1);
            cur_tgt <= cpu_data_sel;
         end else if (pop && !push) begin
            out_cnt <= out_cnt - CNT_W'(1);
         end
         if (stray_hit) begin
            stray_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_bridge_1xn.sv
// Randomised bench for bridge_1xn. The bench plays the CPU and all slaves.
// A reference model (outstanding count, owner, sticky error) predicts the
// combinational outputs each cycle; accepted requests push their expected
// read data into a scoreboard that a separate monitor drains on data_ok.

module tb_bridge_1xn;

   localparam int N   = 3;
   localparam int MAX = 4;
   localparam int SW  = $clog2(N);
   localparam int CW  = $clog2(MAX + 1);

   logic            clk = 1'b0;
   logic            rst;
   logic [SW-1:0]   cpu_data_sel;
   logic            cpu_data_req;
   logic            cpu_data_wr;
   logic [1:0]      cpu_data_size;
   logic [31:0]     cpu_data_addr;
   logic [31:0]     cpu_data_wdata;
   logic [31:0]     cpu_data_rdata;
   logic            cpu_data_addr_ok;
   logic            cpu_data_data_ok;
   logic [N-1:0]    slv_data_req;
   logic [N-1:0]    slv_data_wr;
   logic [2*N-1:0]  slv_data_size;
   logic [32*N-1:0] slv_data_addr;
   logic [32*N-1:0] slv_data_wdata;
   logic [32*N-1:0] slv_data_rdata;
   logic [N-1:0]    slv_data_addr_ok;
   logic [N-1:0]    slv_data_data_ok;
   logic            stray_err;

   bridge_1xn #(.N_SLV(N), .MAX_OUT(MAX)) dut (
      .clk              (clk),
      .rst              (rst),
      .cpu_data_sel     (cpu_data_sel),
      .cpu_data_req     (cpu_data_req),
      .cpu_data_wr      (cpu_data_wr),
      .cpu_data_size    (cpu_data_size),
      .cpu_data_addr    (cpu_data_addr),
      .cpu_data_wdata   (cpu_data_wdata),
      .cpu_data_rdata   (cpu_data_rdata),
      .cpu_data_addr_ok (cpu_data_addr_ok),
      .cpu_data_data_ok (cpu_data_data_ok),
      .slv_data_req     (slv_data_req),
      .slv_data_wr      (slv_data_wr),
      .slv_data_size    (slv_data_size),
      .slv_data_addr    (slv_data_addr),
      .slv_data_wdata   (slv_data_wdata),
      .slv_data_rdata   (slv_data_rdata),
      .slv_data_addr_ok (slv_data_addr_ok),
      .slv_data_data_ok (slv_data_data_ok),
      .stray_err        (stray_err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // reference model state
   int          m_cnt   = 0;
   int          m_tgt   = 0;
   logic        m_stray = 1'b0;
   logic [31:0] sb_q[$];
   logic [31:0] sq[N][$];   // per-slave accepted addresses awaiting response

   function automatic logic [31:0] resp_of(logic [31:0] a, int s);
      return ~a ^ (32'h1111_1111 * 32'(s + 1));
   endfunction

   task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // combinational predictions and model update
   always @(negedge clk) begin
      int          s;
      logic        ex_allow, ex_aok, ex_dok, hit;
      logic [N-1:0]    ex_req, ex_wr;
      logic [2*N-1:0]  ex_size;
      logic [32*N-1:0] ex_addr, ex_wdata;

      s = int'(cpu_data_sel);
      ex_allow = !rst && cpu_data_req && (s < N) && (m_cnt < MAX)
                 && (m_cnt == 0 || s == m_tgt);
      ex_req = '0; ex_wr = '0; ex_size = '0; ex_addr = '0; ex_wdata = '0;
      ex_aok = 1'b0;
      if (ex_allow) begin
         ex_req[s]             = 1'b1;
         ex_wr[s]              = cpu_data_wr;
         ex_size[2*s +: 2]     = cpu_data_size;
         ex_addr[32*s +: 32]   = cpu_data_addr;
         ex_wdata[32*s +: 32]  = cpu_data_wdata;
         ex_aok                = slv_data_addr_ok[s];
      end
      ex_dok = !rst && (m_cnt > 0) && slv_data_data_ok[m_tgt];

      chk("addr_ok",   128'(cpu_data_addr_ok), 128'(ex_aok));
      chk("data_ok",   128'(cpu_data_data_ok), 128'(ex_dok));
      chk("slv_req",   128'(slv_data_req),     128'(ex_req));
      chk("slv_wr",    128'(slv_data_wr),      128'(ex_wr));
      chk("slv_size",  128'(slv_data_size),    128'(ex_size));
      chk("slv_addr",  128'(slv_data_addr),    128'(ex_addr));
      chk("slv_wdata", 128'(slv_data_wdata),   128'(ex_wdata));
      chk("stray_err", 128'(stray_err),        128'(m_stray));
      chk("out_cnt",   128'(dut.out_cnt),      128'(m_cnt));
      if (rst || m_cnt == 0)
         chk("rdata_idle", 128'(cpu_data_rdata), 128'(0));
      else if (!ex_dok)
         chk("rdata_route", 128'(cpu_data_rdata), 128'(slv_data_rdata[32*m_tgt +: 32]));

      hit = 1'b0;
      for (int j = 0; j < N; j++)
         if (slv_data_data_ok[j] && (m_cnt == 0 || j != m_tgt)) hit = 1'b1;

      if (rst) begin
         m_cnt = 0; m_tgt = 0; m_stray = 1'b0;
         sb_q.delete();
         for (int i = 0; i < N; i++) sq[i].delete();
      end else begin
         if (ex_aok) sb_q.push_back(resp_of(cpu_data_addr, s));
         if (ex_aok) m_tgt = s;
         m_cnt = m_cnt + (ex_aok ? 1 : 0) - (ex_dok ? 1 : 0);
         if (hit) m_stray = 1'b1;
         for (int i = 0; i < N; i++) begin
            if (slv_data_data_ok[i] && sq[i].size() > 0) void'(sq[i].pop_front());
            if (slv_data_req[i] && slv_data_addr_ok[i]) sq[i].push_back(slv_data_addr[32*i +: 32]);
         end
      end
   end

   // response monitor
   always @(negedge clk) begin
      logic [31:0] exp_d;
      if (cpu_data_data_ok === 1'b1) begin
         if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rsp_unexpected: got data_ok=1 rdata=%0h want no response", cpu_data_rdata);
         end else begin
            exp_d = sb_q.pop_front();
            chk("rsp_rdata", 128'(cpu_data_rdata), 128'(exp_d));
         end
      end
   end

   int cur_sel = 0;

   task automatic drive_rand(int p_req, int p_aok, int p_dok, int p_rst, int p_stray);
      logic all_empty;
      rst = ($urandom_range(0, 999) < p_rst);
      if ($urandom_range(0, 9) == 0) cur_sel = $urandom_range(0, N);
      cpu_data_sel   = SW'(cur_sel);
      cpu_data_req   = ($urandom_range(0, 99) < p_req);
      cpu_data_wr    = 1'($urandom);
      cpu_data_size  = 2'($urandom);
      cpu_data_addr  = $urandom;
      cpu_data_wdata = $urandom;
      all_empty = 1'b1;
      for (int i = 0; i < N; i++) begin
         slv_data_addr_ok[i]         = ($urandom_range(0, 99) < p_aok);
         slv_data_rdata[32*i +: 32]  = $urandom;
         slv_data_data_ok[i]         = 1'b0;
         if (sq[i].size() > 0) begin
            all_empty = 1'b0;
            if ($urandom_range(0, 99) < p_dok) begin
               slv_data_data_ok[i]        = 1'b1;
               slv_data_rdata[32*i +: 32] = resp_of(sq[i][0], i);
            end
         end
      end
      if (all_empty && p_stray > 0 && $urandom_range(0, 99) < p_stray)
         slv_data_data_ok[$urandom_range(0, N-1)] = 1'b1;
   endtask

   // len, p_req, p_aok, p_dok, p_rst(per mille), p_stray
   int ph[5][6] = '{
      '{30,  100, 100,   0, 0, 0},
      '{800,  80,  70,  40, 3, 2},
      '{800,  90, 100,  90, 3, 2},
      '{800,  60,  40,  15, 3, 2},
      '{60,    0,   0, 100, 0, 0}
   };

   initial begin
      rst = 1'b1;
      cpu_data_sel = '0; cpu_data_req = 1'b0; cpu_data_wr = 1'b0;
      cpu_data_size = '0; cpu_data_addr = '0; cpu_data_wdata = '0;
      slv_data_rdata = '0; slv_data_addr_ok = '0; slv_data_data_ok = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      for (int p = 0; p < 5; p++) begin
         for (int c = 0; c < ph[p][0]; c++) begin
            @(posedge clk);
            #1 drive_rand(ph[p][1], ph[p][2], ph[p][3], ph[p][4], ph[p][5]);
         end
      end
      @(posedge clk);
      #1 slv_data_data_ok = '0; cpu_data_req = 1'b0; rst = 1'b0;
      @(negedge clk);
      #1 chk("drain_empty", 128'(sb_q.size()), 128'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bridge_1xn.md
# bridge_1xn

Parametrised 1-to-N demultiplexer for the CPU data-side SRAM-like bus (req/wr/size/addr/wdata, addr_ok/data_ok). It sits between the CPU data port and N downstream slaves (D-cache, uncached/config path, further ports), steering each request by a per-request target select. It tracks outstanding transactions so every `data_ok`/`rdata` is returned from the slave that accepted the request, even after `cpu_data_sel` has changed. To keep responses in order, it blocks a request to a different target until all in-flight transactions drain.

## Interface
- `N_SLV`, default 2: number of downstream slaves, range 2..8.
- `MAX_OUT`, default 4: maximum accepted-but-unanswered transactions, range 1..15.
- `SEL_W`, default `$clog2(N_SLV)`: select width, derived.
- `CNT_W`, default `$clog2(MAX_OUT+1)`: outstanding counter width, derived.

Ports:
- `clk`  in  1  clock; one clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `cpu_data_sel`  in  SEL_W  target slave index for the current request; valid while `cpu_data_req`=1.
- `cpu_data_req` / `cpu_data_wr` / `cpu_data_size[1:0]` / `cpu_data_addr[31:0]` / `cpu_data_wdata[31:0]`  in  CPU request fields.
- `cpu_data_rdata`  out  32  read data from the responding slave.
- `cpu_data_addr_ok`  out  1  request accepted.
- `cpu_data_data_ok`  out  1  response returned.
- `slv_data_req` / `slv_data_wr`  out  N_SLV  per-slave request and write flag.
- `slv_data_size`  out  2*N_SLV  per-slave size; slice i at [2i+1:2i].
- `slv_data_addr` / `slv_data_wdata`  out  32*N_SLV  per-slave address and write data; slice i at [32i+31:32i].
- `slv_data_rdata`  in  32*N_SLV  per-slave read data.
- `slv_data_addr_ok` / `slv_data_data_ok`  in  N_SLV  per-slave handshakes.
- `stray_err`  out  1  sticky flag: `data_ok` seen from an unexpected slave.

## Operation
State registers:
- `out_cnt[CNT_W]`: number of outstanding transactions.
- `cur_tgt[SEL_W]`: target of the outstanding transactions.
- `stray_err`.

Issue gate:
- `allow = !rst && cpu_data_req && (out_cnt < MAX_OUT) && (out_cnt == 0 || cpu_data_sel == cur_tgt)`.
- `cpu_data_sel` ≥ `N_SLV` is never allowed. The request stalls, and is blocked even when `out_cnt` = 0.

Forwarding (combinational):
- For slave i = `cpu_data_sel` with `allow`=1: `slv_data_req[i]`=1, and wr/size/addr/wdata copy the CPU fields.
- All other slices (and all slices when `allow`=0) drive 0.
- `cpu_data_addr_ok = allow && slv_data_addr_ok[cpu_data_sel]`.

Response routing:
- `cpu_data_data_ok = (out_cnt != 0) && slv_data_data_ok[cur_tgt]`.
- `cpu_data_rdata` = slice `cur_tgt` of `slv_data_rdata` when `out_cnt != 0`, else 0.

Counter update on the clock edge:
- `push = cpu_data_addr_ok`, `pop = cpu_data_data_ok`.
- push only: `out_cnt` +1, and `cur_tgt <= cpu_data_sel`.
- pop only: `out_cnt` −1.
- push and pop together: count unchanged, and `cur_tgt` is held (it already equals `cpu_data_sel` by the gate).

Stray detection: `stray_err` sets on any cycle where a slave j raises `data_ok` and either
- `out_cnt` = 0, or
- j ≠ `cur_tgt`.

`stray_err` clears only on `rst`.

Boundary conditions:
- At `out_cnt` = MAX_OUT, requests stall. A pop in that cycle does not re-open the gate the same cycle: the gate uses the registered count.
- A target switch happens only when `out_cnt` = 0. The first accepted request to the new target updates `cur_tgt`.
- A slave raising `data_ok` in the same cycle as its `addr_ok` for that same transaction is unsupported. With `out_cnt` = 0 it is flagged as stray.
- `rst` asserted mid-transaction discards all outstanding state. Late `data_ok` arriving after reset is flagged as stray.

## Timing
- Request path fully combinational: zero added latency, `addr_ok` in the same cycle as the slave's `addr_ok`.
- Response path combinational from the registered `cur_tgt`: `data_ok`/`rdata` in the same cycle as the slave's.
- Outstanding state updates at the rising edge after a handshake.
- Reset values: `out_cnt`=0, `cur_tgt`=0, `stray_err`=0.
- During `rst`=1, all `slv_data_*` outputs are 0, and `cpu_data_addr_ok`, `cpu_data_data_ok` and `cpu_data_rdata` are 0.
- Back-to-back accepts are allowed every cycle up to MAX_OUT.

## Test plan
1. **Basic read.** N_SLV=2, sel=1, read of 0x1FAF_0000; slave 1 gives `addr_ok` at cycle 0 and `data_ok` with rdata=0xDEAD_BEEF at cycle 2.
   - Required: `cpu_data_addr_ok` at 0, `cpu_data_data_ok` and rdata 0xDEAD_BEEF at 2.
   - Required: `slv_data_req[0]` stays 0 throughout.
2. **Fill to MAX_OUT.** MAX_OUT=4; four back-to-back accepts to slave 0, no `data_ok`.
   - Required: the fifth request sees `cpu_data_addr_ok`=0 and `slv_data_req`=0.
   - Required: after one `data_ok`, the request is accepted on the next cycle.
3. **Target switch blocked.** Two outstanding to slave 0, then a request with sel=1.
   - Required: stalled with `slv_data_req`=0 until the second slave-0 `data_ok`.
   - Required: accepted the following cycle, and `cur_tgt` becomes 1.
4. **Simultaneous push and pop.** `out_cnt`=2; slave 0 returns `data_ok` while a new slave-0 request is accepted.
   - Required: `out_cnt` stays 2.
   - Required: drains with exactly two more `data_ok`.
5. **Stray response.** Slave 1 raises `data_ok` with `out_cnt`=0.
   - Required: `cpu_data_data_ok`=0, and `stray_err`=1 from the next cycle until `rst`.
6. **Reset mid-flight.** `rst` asserted with `out_cnt`=3.
   - Required: next cycle `out_cnt`=0, all outputs 0, `stray_err`=0.
   - Required: a subsequent request to either slave is accepted immediately.
